lector_bus_triestado: RTL and testbench

LECTOR_BUS_TRIESTADO -- requirements
Module: lector_bus_triestado

---
 rtl/lector_bus_triestado.sv | 103 ++++++++++
 tb/tb_lector_bus_triestado.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lector_bus_triestado.sv
// Sequential reader for four tristate slot registers sharing one 4-bit bus.
// Each masked slot gets WAIT_CYCLES+1 OE cycles, a capture, then one released-bus gap.
module lector_bus_triestado #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mask,
  input  logic [3:0]  bus,
  output logic [3:0]  OE_sel,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_SAMPLE,
    S_GAP,
    S_DONE
  } state_t;

  localparam bit         NO_WAIT     = (WAIT_CYCLES == 0);
  localparam bit         ONE_WAIT    = (WAIT_CYCLES == 1);
  localparam logic [3:0] LAST_SETTLE = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_pending;
  logic [3:0]  r_cnt;
  logic [15:0] r_data;
  logic [3:0]  w_pick;
  logic        w_oe_on;
  logic        w_capture;

  // Lowest-index unread slot; stays fixed for the whole OE window of that slot.
  assign w_pick    = r_pending & (~r_pending + 4'd1);
  assign w_oe_on   = (r_state == S_SELECT) || (r_state == S_SETTLE) ||
                     (r_state == S_SAMPLE);
  assign w_capture = (r_state == S_SAMPLE) || ((r_state == S_SELECT) && NO_WAIT);
  assign data_out  = r_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (mask == 4'd0) ? S_DONE : S_SELECT;
      end
      S_SELECT: begin
        if (NO_WAIT)       w_next = S_GAP;
        else if (ONE_WAIT) w_next = S_SAMPLE;
        else               w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == LAST_SETTLE) w_next = S_SAMPLE;
      end
      S_SAMPLE: w_next = S_GAP;
      S_GAP:    w_next = (r_pending == 4'd0) ? S_DONE : S_SELECT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    OE_sel = 4'd0;
    busy   = 1'b0;
    done   = 1'b0;
    if (w_oe_on) OE_sel = w_pick;
    busy = w_oe_on || (r_state == S_GAP);
    done = (r_state == S_DONE);
  end

  // r_pending holds the latched mask minus the slots already captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 4'd0;
      r_cnt     <= 4'd0;
      r_data    <= 16'd0;
    end else begin
      if ((r_state == S_IDLE) && start) r_pending <= mask;
      else if (w_capture)               r_pending <= r_pending & ~w_pick;

      if (r_state == S_SELECT)      r_cnt <= 4'd1;
      else if (r_state == S_SETTLE) r_cnt <= r_cnt + 4'd1;
      else                          r_cnt <= 4'd0;

      if (w_capture) begin
        for (int i = 0; i < 4; i++) begin
          if (w_pick[i]) r_data[4*i +: 4] <= bus;
        end
      end
    end
  end

endmodule

// File: tb/tb_lector_bus_triestado.sv
// Directed bench: one reader with WAIT_CYCLES=1 and one with WAIT_CYCLES=0,
// each fed by a model of four slot registers that drive the bus on their OE bit.
module tb_lector_bus_triestado;

  logic        clk = 1'b0;
  logic        rst;
  logic        st1, st0;
  logic [3:0]  mk1, mk0;
  logic [3:0]  bus1, bus0;
  logic [3:0]  oe1, oe0;
  logic [15:0] do1, do0;
  logic        busy1, busy0, done1, done0;
  logic [3:0]  slots1 [4];
  logic [3:0]  slots0 [4];

  logic [3:0]  t_oe   [16];
  logic        t_done [16];
  logic        t_busy [16];
  logic [15:0] t_data [16];

  int n_chk  = 0;
  int n_fail = 0;
  int acc;

  always #5 clk = ~clk;

  always_comb begin
    bus1 = 4'h0;
    bus0 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (oe1[i]) bus1 = slots1[i];
      if (oe0[i]) bus0 = slots0[i];
    end
  end

  lector_bus_triestado #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .start(st1), .mask(mk1), .bus(bus1),
    .OE_sel(oe1), .data_out(do1), .busy(busy1), .done(done1)
  );

  lector_bus_triestado #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .start(st0), .mask(mk0), .bus(bus0),
    .OE_sel(oe0), .data_out(do0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a sweep in cycle 0 and record cycles 1..ncyc at the falling edge.
  task automatic sweep(input bit w0, input logic [3:0] m, input int ncyc);
    for (int c = 0; c < 16; c++) begin
      t_oe[c] = 4'h0; t_done[c] = 1'b0; t_busy[c] = 1'b0; t_data[c] = 16'h0;
    end
    if (w0) begin mk0 = m; st0 = 1'b1; end
    else    begin mk1 = m; st1 = 1'b1; end
    @(posedge clk);
    #1;
    st0 = 1'b0;
    st1 = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      t_oe[c]   = w0 ? oe0   : oe1;
      t_done[c] = w0 ? done0 : done1;
      t_busy[c] = w0 ? busy0 : busy1;
      t_data[c] = w0 ? do0   : do1;
    end
  endtask

  initial begin
    rst = 1'b1; st1 = 1'b0; st0 = 1'b0; mk1 = 4'h0; mk0 = 4'h0;
    slots1[0] = 4'hA; slots1[1] = 4'h5; slots1[2] = 4'h3; slots1[3] = 4'h7;
    slots0[0] = 4'h1; slots0[1] = 4'h2; slots0[2] = 4'h3; slots0[3] = 4'h4;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", oe1, 4'h0);
    chk("rst_data", do1, 16'h0000);
    chk("rst_data_w0", do0, 16'h0000);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    rst = 1'b0;

    // Two-slot sweep, WAIT_CYCLES=1, mask 0101
    sweep(1'b0, 4'b0101, 9);
    chk("two_oe_c1", t_oe[1], 4'b0001);
    chk("two_oe_c2", t_oe[2], 4'b0001);
    chk("two_oe_c3", t_oe[3], 4'b0000);
    chk("two_oe_c4", t_oe[4], 4'b0100);
    chk("two_oe_c5", t_oe[5], 4'b0100);
    chk("two_oe_c6", t_oe[6], 4'b0000);
    chk("two_busy_c1", t_busy[1], 1'b1);
    chk("two_busy_c6", t_busy[6], 1'b1);
    chk("two_done_c6", t_done[6], 1'b0);
    chk("two_done_c7", t_done[7], 1'b1);
    chk("two_busy_c7", t_busy[7], 1'b0);
    chk("two_done_c8", t_done[8], 1'b0);
    chk("two_data_c2", t_data[2], 16'h0000);
    chk("two_data_c3", t_data[3], 16'h000A);
    chk("two_data_c5", t_data[5], 16'h000A);
    chk("two_data_end", do1, 16'h030A);

    // Retention of unmasked nibbles
    slots1[1] = 4'hF;
    sweep(1'b0, 4'b0010, 5);
    chk("ret_oe_c1", t_oe[1], 4'b0010);
    chk("ret_oe_c3", t_oe[3], 4'b0000);
    chk("ret_done_c4", t_done[4], 1'b1);
    chk("ret_data", do1, 16'h03FA);

    // Empty mask
    sweep(1'b0, 4'b0000, 3);
    chk("empty_done_c1", t_done[1], 1'b1);
    chk("empty_done_c2", t_done[2], 1'b0);
    acc = 0;
    for (int c = 1; c <= 3; c++) acc += int'(t_busy[c]) + int'(t_oe[c] != 4'h0);
    chk("empty_no_activity", acc, 0);
    chk("empty_data", do1, 16'h03FA);

    // Full mask, WAIT_CYCLES=0
    sweep(1'b1, 4'b1111, 10);
    chk("full_oe_c1", t_oe[1], 4'b0001);
    chk("full_oe_c2", t_oe[2], 4'b0000);
    chk("full_oe_c3", t_oe[3], 4'b0010);
    chk("full_oe_c4", t_oe[4], 4'b0000);
    chk("full_oe_c5", t_oe[5], 4'b0100);
    chk("full_oe_c6", t_oe[6], 4'b0000);
    chk("full_oe_c7", t_oe[7], 4'b1000);
    chk("full_oe_c8", t_oe[8], 4'b0000);
    chk("full_done_c8", t_done[8], 1'b0);
    chk("full_done_c9", t_done[9], 1'b1);
    chk("full_data", do0, 16'h4321);
    acc = 0;
    for (int c = 1; c <= 10; c++) if ($countones(t_oe[c]) > 1) acc++;
    chk("full_onehot", acc, 0);

    // start and mask changes during a sweep are ignored
    slots1[0] = 4'h6; slots1[2] = 4'h9; slots1[3] = 4'hE;
    mk1 = 4'b0101; st1 = 1'b1;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    acc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done1) acc++;
      if (c == 7) chk("ign_done_c7", done1, 1'b1);
      if (oe1[3]) chk("ign_slot3_oe", oe1, 4'b0000);
      if (c == 2) begin st1 = 1'b1; mk1 = 4'b1000; end
      if (c == 3) st1 = 1'b0;
    end
    chk("ign_done_count", acc, 1);
    chk("ign_data", do1, 16'h09F6);

    // Reset held two cycles in the middle of a sweep, start asserted alongside
    sweep(1'b0, 4'b1111, 3);
    chk("mid_oe_c3", t_oe[3], 4'b0000);
    rst = 1'b1;
    st1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_oe", oe1, 4'h0);
    chk("mid_rst_data", do1, 16'h0000);
    chk("mid_rst_busy", busy1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    st1 = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc += int'(done1) + int'(busy1) + int'(oe1 != 4'h0);
    end
    chk("mid_no_activity", acc, 0);
    chk("mid_data_hold", do1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
